// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter through its transmit/tx_byte/tx_free handshake.
// Bytes offered while full are dropped and counted so trace overruns are visible to the host.
module uart_tx_fifo #(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [7:0]            in_byte,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  tx_free,
   output logic                  transmit,
   output logic [7:0]            tx_byte,
   output logic [DEPTH_LOG2:0]   level,
   output logic                  overflow,
   output logic [15:0]           drop_count,
   input  logic                  clear_overflow
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
   localparam logic [DEPTH_LOG2:0]   CNT_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      SEND  = 2'd2,
      HOLD  = 2'd3
   } state_t;

   state_t                state;
   logic [7:0]            mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic [DEPTH_LOG2:0]   count;
   logic                  full;
   logic                  push;
   logic                  pop;
   logic                  drop;

   // count never exceeds DEPTH, so its MSB alone marks the full condition
   assign full     = count[DEPTH_LOG2];
   assign in_ready = !full && !rst;
   assign push     = in_valid && in_ready;
   assign drop     = in_valid && !in_ready && !rst;
   assign pop      = (state == FETCH);
   assign transmit = (state == SEND) && !rst;
   assign level    = count;

   // NOTE: the storage array is deliberately not reset; stale entries are unreachable once pointers and count are cleared.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_byte;
   end

   // NOTE: every register here uses non-blocking assignment so all decisions see pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         tx_byte    <= 8'h00;
         overflow   <= 1'b0;
         drop_count <= 16'h0000;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;

         case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase

         // a drop on the same edge as a clear survives as the first counted drop
         if (clear_overflow) begin
            overflow   <= drop;
            drop_count <= drop ? 16'h0001 : 16'h0000;
         end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'h0001;
         end

         case (state)
            IDLE: begin
               if (count != '0 && tx_free) state <= FETCH;
            end
            FETCH: begin
               tx_byte <= mem[rd_ptr];
               rd_ptr  <= rd_ptr + PTR_ONE;
               state   <= SEND;
            end
            SEND:    state <= HOLD;
            HOLD:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed steps, a queue-based FIFO model and a serial UART model.
module tb_uart_tx_fifo;

   localparam int DL2   = 4;
   localparam int DEPTH = 16;
   localparam int BIT   = 3;

   logic         clk = 1'b0;
   logic         rst;
   logic [7:0]   in_byte;
   logic         in_valid;
   logic         in_ready;
   logic         tx_free;
   logic         transmit;
   logic [7:0]   tx_byte;
   logic [DL2:0] level;
   logic         overflow;
   logic [15:0]  drop_count;
   logic         clear_overflow;

   logic uart_en;
   logic man_free;
   logic uart_free;
   logic serial;

   int total = 0;
   int bad   = 0;
   int viol  = 0;
   int frame_err = 0;
   logic [7:0] tx_log [$];
   logic [7:0] rx_q   [$];

   assign tx_free = uart_en ? uart_free : man_free;

   uart_tx_fifo #(.DEPTH_LOG2(DL2)) dut (
      .clk            (clk),
      .rst            (rst),
      .in_byte        (in_byte),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .tx_free        (tx_free),
      .transmit       (transmit),
      .tx_byte        (tx_byte),
      .level          (level),
      .overflow       (overflow),
      .drop_count     (drop_count),
      .clear_overflow (clear_overflow)
   );

   always #5 clk = ~clk;

   // records every byte the UART would latch, and any request made while the UART is busy
   always @(negedge clk) begin
      if (transmit) tx_log.push_back(tx_byte);
      if (transmit && !tx_free) viol++;
   end

   // UART transmitter model: latches on the edge closing the transmit cycle, then sends 8N1
   initial begin
      logic [7:0] sh;
      uart_free = 1'b1;
      serial    = 1'b1;
      forever begin
         @(negedge clk);
         if (uart_en && transmit) begin
            sh = tx_byte;
            @(posedge clk);
            #1;
            uart_free = 1'b0;
            for (int b = 0; b < 10; b++) begin
               serial = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : sh[b-1];
               repeat (BIT) @(posedge clk);
               #1;
            end
            uart_free = 1'b1;
         end
      end
   end

   // serial decoder: samples each bit at its first falling clock edge
   initial begin
      logic [7:0] d;
      forever begin
         @(negedge clk);
         if (serial === 1'b0) begin
            for (int i = 0; i < 8; i++) begin
               repeat (BIT) @(negedge clk);
               d[i] = serial;
            end
            repeat (BIT) @(negedge clk);
            if (serial !== 1'b1) frame_err++;
            rx_q.push_back(d);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_log(input int n, input int budget, input string tag);
      int cyc = 0;
      while (tx_log.size() < n && cyc < budget) begin
         step();
         cyc++;
      end
      check(tag, tx_log.size(), n);
   endtask

   task automatic fill(input int n, input logic [7:0] first);
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1;
         in_byte  = first + 8'(i);
         step();
      end
      in_valid = 1'b0;
   endtask

   initial begin
      int base;
      int cyc;
      int mdrop;
      logic v;
      logic [7:0] b;
      logic [7:0] mq  [$];
      logic [7:0] exp [$];

      rst            = 1'b1;
      in_valid       = 1'b0;
      in_byte        = 8'h00;
      clear_overflow = 1'b0;
      man_free       = 1'b1;
      uart_en        = 1'b0;

      // reset state
      repeat (3) step();
      check("rst_in_ready", in_ready, 0);
      check("rst_transmit", transmit, 0);
      check("rst_tx_byte", tx_byte, 8'h00);
      check("rst_level", level, 0);
      check("rst_overflow", overflow, 0);
      check("rst_drop_count", drop_count, 0);
      rst = 1'b0;
      #1;
      check("post_rst_in_ready", in_ready, 1);

      // single byte latency
      in_valid = 1'b1;
      in_byte  = 8'hA5;
      step();
      in_valid = 1'b0;
      check("lat_e0_level", level, 1);
      check("lat_e0_transmit", transmit, 0);
      step();
      check("lat_e1_level", level, 1);
      check("lat_e1_transmit", transmit, 0);
      step();
      check("lat_e2_transmit", transmit, 1);
      check("lat_e2_tx_byte", tx_byte, 8'hA5);
      check("lat_e2_level", level, 0);
      step();
      check("lat_e3_transmit", transmit, 0);
      check("lat_e3_tx_byte_hold", tx_byte, 8'hA5);
      check("lat_pulse_count", tx_log.size(), 1);
      step();
      check("lat_e4_transmit", transmit, 0);
      step();

      // fill with UART busy, then overrun
      man_free = 1'b0;
      fill(DEPTH, 8'h30);
      check("full_level", level, DEPTH);
      check("full_in_ready", in_ready, 0);
      in_valid = 1'b1;
      in_byte  = 8'h11;
      step();
      in_byte  = 8'h22;
      step();
      in_valid = 1'b0;
      check("ovf_flag", overflow, 1);
      check("ovf_drop_count", drop_count, 2);
      check("ovf_level", level, DEPTH);
      check("busy_no_transmit", tx_log.size(), 1);
      base = tx_log.size();
      man_free = 1'b1;
      wait_log(base + DEPTH, 200, "drain16_count");
      for (int i = 0; i < DEPTH; i++)
         check($sformatf("drain16_byte%0d", i), tx_log[base+i], 8'h30 + 8'(i));
      repeat (3) step();
      check("drain16_level", level, 0);

      // clear alone, then clear colliding with a drop
      clear_overflow = 1'b1;
      step();
      clear_overflow = 1'b0;
      check("clr_overflow", overflow, 0);
      check("clr_drop_count", drop_count, 0);
      man_free = 1'b0;
      fill(DEPTH, 8'h80);
      in_valid = 1'b1;
      repeat (3) step();
      check("drop3_count", drop_count, 3);
      clear_overflow = 1'b1;
      step();
      check("clr_drop_overflow", overflow, 1);
      check("clr_drop_count", drop_count, 1);
      in_valid = 1'b0;
      step();
      clear_overflow = 1'b0;
      check("clr2_overflow", overflow, 0);
      check("clr2_drop_count", drop_count, 0);
      base = tx_log.size();
      man_free = 1'b1;
      wait_log(base + DEPTH, 200, "drain_b_count");
      repeat (5) step();
      man_free = 1'b0;

      // random traffic against a queue model while the UART is busy
      mdrop = 0;
      for (int c = 0; c < 40; c++) begin
         v = ($urandom_range(0, 9) < 6);
         b = 8'($urandom);
         in_valid = v;
         in_byte  = b;
         step();
         if (v) begin
            if (mq.size() < DEPTH) mq.push_back(b);
            else if (mdrop < 65535) mdrop++;
         end
         check("rnd_level", level, mq.size());
         check("rnd_drop_count", drop_count, mdrop);
         check("rnd_overflow", overflow, (mdrop != 0));
      end
      in_valid = 1'b0;
      base = tx_log.size();
      man_free = 1'b1;
      wait_log(base + mq.size(), 400, "rnd_drain_count");
      for (int i = 0; i < mq.size(); i++)
         check("rnd_drain_byte", tx_log[base+i], mq[i]);
      repeat (5) step();
      clear_overflow = 1'b1;
      step();
      clear_overflow = 1'b0;

      // real UART model, pointers wrap several times
      uart_en = 1'b1;
      for (int i = 0; i < 40; i++) begin
         b = 8'($urandom);
         cyc = 0;
         while (!in_ready && cyc < 2000) begin
            step();
            cyc++;
         end
         check("uart_in_ready", in_ready, 1);
         in_valid = 1'b1;
         in_byte  = b;
         exp.push_back(b);
         step();
         in_valid = 1'b0;
         repeat ($urandom_range(0, 2)) step();
      end
      cyc = 0;
      while (rx_q.size() < 40 && cyc < 4000) begin
         step();
         cyc++;
      end
      check("uart_rx_count", rx_q.size(), 40);
      for (int i = 0; i < 40; i++)
         check($sformatf("uart_rx_byte%0d", i), rx_q[i], exp[i]);
      check("uart_busy_violations", viol, 0);
      check("uart_frame_errors", frame_err, 0);
      check("uart_no_drops", drop_count, 0);
      check("uart_end_level", level, 0);

      // reset while a SEND is in flight with bytes buffered
      uart_en  = 1'b0;
      man_free = 1'b0;
      repeat (2) step();
      fill(5, 8'hC0);
      check("rst_mid_level5", level, 5);
      man_free = 1'b1;
      cyc = 0;
      while (!transmit && cyc < 50) begin
         step();
         cyc++;
      end
      check("rst_mid_send_seen", transmit, 1);
      rst = 1'b1;
      #1;
      check("rst_mid_transmit", transmit, 0);
      check("rst_mid_in_ready", in_ready, 0);
      step();
      rst = 1'b0;
      #1;
      check("rst_mid_level", level, 0);
      check("rst_mid_in_ready_after", in_ready, 1);
      base = tx_log.size();
      repeat (20) step();
      check("rst_mid_quiet", tx_log.size(), base);
      in_valid = 1'b1;
      in_byte  = 8'h5A;
      step();
      in_valid = 1'b0;
      wait_log(base + 1, 20, "rst_mid_new_count");
      check("rst_mid_new_byte", tx_log[base], 8'h5A);
      repeat (4) step();

      // drop counter saturation
      man_free = 1'b0;
      fill(DEPTH, 8'h00);
      clear_overflow = 1'b1;
      step();
      clear_overflow = 1'b0;
      in_valid = 1'b1;
      repeat (65534) step();
      check("sat_fffe", drop_count, 16'hFFFE);
      step();
      check("sat_ffff", drop_count, 16'hFFFF);
      repeat (70000 - 65535) step();
      check("sat_hold", drop_count, 16'hFFFF);
      check("sat_overflow", overflow, 1);
      check("sat_level", level, DEPTH);
      clear_overflow = 1'b1;
      step();
      check("sat_clr_drop_count", drop_count, 1);
      check("sat_clr_overflow", overflow, 1);
      in_valid       = 1'b0;
      clear_overflow = 1'b0;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte buffer placed directly upstream of the UART transmitter. It accepts bytes from the trace/packet path over a valid/ready interface and stores them in a synchronous FIFO. It drains them into the UART one at a time using the UART's `transmit` / `tx_byte` / `tx_free` handshake. Bytes that arrive while the FIFO is full are dropped and counted, so trace overruns can be seen by the host.

## Interface
- `DEPTH_LOG2`, default 4: FIFO depth is 2^DEPTH_LOG2 bytes. Legal range is 2..10.
- `clk` in 1: clock, shared with the UART.
- `rst` in 1: reset, synchronous, active-high.
- `in_byte` in 8: byte offered by the producer.
- `in_valid` in 1: `in_byte` is valid this cycle.
- `in_ready` out 1: `!full && !rst`. Combinational from the registered count.
- `tx_free` in 1: UART transmit register is idle.
- `transmit` out 1: one-cycle request to the UART. The UART samples it together with `tx_byte`.
- `tx_byte` out 8: registered byte presented to the UART.
- `level` out DEPTH_LOG2+1: current FIFO occupancy.
- `overflow` out 1: sticky flag. Set when any byte is dropped.
- `drop_count` out 16: number of dropped bytes. Saturates at 0xFFFF.
- `clear_overflow` in 1: clears `overflow` and `drop_count`.

## Operation
- **Storage**
  - Memory of 2^DEPTH_LOG2 x 8.
  - Write and read pointers are DEPTH_LOG2 bits and wrap modulo depth.
  - Count is DEPTH_LOG2+1 bits. Full when count == 2^DEPTH_LOG2; empty when count == 0.
- **Push**
  - A push occurs on an edge where `in_valid && in_ready`: mem[wr] <= `in_byte`, then wr++.
- **Drop**
  - A drop occurs on an edge where `in_valid && !in_ready && !rst`.
  - On a drop: `overflow` <= 1, and `drop_count` <= `drop_count`+1 unless it is already 0xFFFF.
- **Clear**
  - `clear_overflow` zeroes both `overflow` and `drop_count`.
  - If a clear and a drop occur on the same edge: `overflow`=1 and `drop_count`=1.
- **Drain FSM** (2-bit state):
  - IDLE: if `count != 0 && tx_free`, go to FETCH.
  - FETCH: `tx_byte` <= mem[rd], rd++, count decremented. Go to SEND.
  - SEND: `transmit`=1 for exactly this cycle. Go to HOLD unconditionally.
  - HOLD: gives the UART one cycle to drop `tx_free`. Go to IDLE.
- `transmit` is `(state==SEND) && !rst`. No other state drives it.
- **Simultaneous push and pop (FETCH)**
  - count is unchanged.
  - `in_ready` is evaluated on the pre-edge count. A push offered while full is dropped even if FETCH frees a slot on that same edge.
- `level` equals count at all times.

## Timing
- **Reset values:** `transmit`=0, `tx_byte`=0x00, `level`=0, `overflow`=0, `drop_count`=0, state=IDLE, pointers=0, `in_ready`=0 while `rst` is high and 1 on the first cycle after.
- **Reset mid-operation:** FIFO contents and any pending SEND are discarded, and `transmit` is low during the reset cycle.
- **Latency:** byte pushed at edge E with the FIFO empty, FSM in IDLE and `tx_free`=1:
  - `level`=1 after E.
  - FETCH in the cycle after E+1; `tx_byte` valid from E+2.
  - `transmit` high between E+2 and E+3; the UART latches the byte at E+3.
  - HOLD until E+4, then IDLE.
- **Throughput:** at most one byte per 4 cycles. In practice throughput is bounded by the UART, which holds `tx_free` low for 10 bit periods.
- If `tx_free` is low, the FSM waits in IDLE indefinitely and the FIFO keeps accepting data.
- `tx_byte` holds its value after SEND until the next FETCH.
- **Pointer wrap:** `rd`/`wr` wrap from 2^DEPTH_LOG2-1 to 0 with no data corruption.

## Test plan
- Reset, push 0xA5 with `tx_free`=1 -> `transmit` high for exactly one cycle, with `tx_byte`=0xA5 at the 3rd edge after the push; `level` reads 1 then 0.
- Hold `tx_free`=0 and push 16 bytes (DEPTH_LOG2=4) -> `in_ready`=0 and `level`=16. Push 0x11, 0x22 -> both dropped, `overflow`=1, `drop_count`=2. Release `tx_free` -> 16 bytes are emitted in order.
- Assert `clear_overflow` on the same edge as a drop -> `overflow`=1, `drop_count`=1. Clear alone -> both are 0.
- Hook up the real uart model with 40 random bytes, repeatedly filling past the wrap point -> the serial stream decodes to an identical byte sequence, and no `transmit` occurs while `tx_free`=0.
- Assert `rst` during SEND with 5 bytes buffered -> `transmit` is 0 in the reset cycle, `level`=0, and no further `transmit` until new data is pushed.
- Force 70000 drops -> `drop_count` saturates at 0xFFFF and does not wrap.
